// File: rtl/xrv_id.sv
// RV32I decode stage: one-entry hold buffer, register file, load-use interlock, immediate decode.
// Define XRV_ID_WB_BYPASS_EN to forward same-cycle writeback data to operand reads.
module xrv_id (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inst_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_inst_pc,
  input  logic        i_inst_is_compressed,
  output logic        o_stalling,
  input  logic        i_flush,
  input  logic        i_ex_stall,
  input  logic        i_ex_load_valid,
  input  logic [4:0]  i_ex_load_rd,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_next_pc,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_rs1_val,
  output logic [31:0] o_id_rs2_val,
  output logic [31:0] o_id_imm,
  output logic [4:0]  o_id_rd,
  output logic        o_id_rd_we,
  output logic        o_id_illegal
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {S_EMPTY, S_FULL} hold_state_t;

  hold_state_t       r_state;
  logic [XLEN-1:0]   r_hold_inst, r_hold_pc;
  logic              r_hold_comp;
  logic [XLEN-1:0]   r_regs [1:31];

  logic              r_id_valid, r_id_rd_we, r_id_illegal;
  logic [XLEN-1:0]   r_id_pc, r_id_next_pc, r_id_inst, r_id_rs1_val, r_id_rs2_val, r_id_imm;
  logic [RW-1:0]     r_id_rd;

  logic              w_src_valid, w_src_comp, w_hazard, w_accept;
  logic [XLEN-1:0]   w_src_inst, w_src_pc, w_imm, w_rs1_val, w_rs2_val;
  logic [6:0]        w_opcode;
  logic [RW-1:0]     w_rs1, w_rs2, w_rd;
  logic              w_rs1_used, w_rs2_used, w_illegal, w_rd_we;

  assign w_src_valid = (r_state == S_FULL) | i_inst_valid;
  assign w_src_inst  = (r_state == S_FULL) ? r_hold_inst : i_inst;
  assign w_src_pc    = (r_state == S_FULL) ? r_hold_pc   : i_inst_pc;
  assign w_src_comp  = (r_state == S_FULL) ? r_hold_comp : i_inst_is_compressed;
  assign w_opcode    = w_src_inst[6:0];
  assign w_rd        = w_src_inst[11:7];
  assign w_rs1       = w_src_inst[19:15];
  assign w_rs2       = w_src_inst[24:20];

  // Opcode class decode: legality, operand usage, immediate format
  always_comb begin
    w_illegal  = 1'b0;
    w_rs1_used = 1'b1;
    w_rs2_used = 1'b0;
    w_imm      = '0;
    unique case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        w_rs1_used = 1'b0;
        w_imm      = {w_src_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        w_rs1_used = 1'b0;
        w_imm      = {{11{w_src_inst[31]}}, w_src_inst[31], w_src_inst[19:12],
                      w_src_inst[20], w_src_inst[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:
        w_imm = {{20{w_src_inst[31]}}, w_src_inst[31:20]};
      OP_STORE: begin
        w_rs2_used = 1'b1;
        w_imm      = {{20{w_src_inst[31]}}, w_src_inst[31:25], w_src_inst[11:7]};
      end
      OP_BRANCH: begin
        w_rs2_used = 1'b1;
        w_imm      = {{19{w_src_inst[31]}}, w_src_inst[31], w_src_inst[7],
                      w_src_inst[30:25], w_src_inst[11:8], 1'b0};
      end
      OP_OP:   w_rs2_used = 1'b1;
      OP_MISC: ;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rd_we = (w_rd != '0) & ~w_illegal &
                   (w_opcode != OP_BRANCH) & (w_opcode != OP_STORE) & (w_opcode != OP_MISC);

  assign w_hazard = i_ex_load_valid & (i_ex_load_rd != '0) &
                    ((w_rs1_used & (w_rs1 == i_ex_load_rd)) | (w_rs2_used & (w_rs2 == i_ex_load_rd)));
  assign w_accept   = w_src_valid & ~i_ex_stall & ~w_hazard & ~i_flush;
  assign o_stalling = ((r_state == S_FULL) | i_inst_valid) & ~w_accept;

  // Operand read; x0 is hardwired zero
  always_comb begin
    w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`ifdef XRV_ID_WB_BYPASS_EN
    if (i_wb_we && (i_wb_rd == w_rs1) && (w_rs1 != '0)) w_rs1_val = i_wb_data;
    if (i_wb_we && (i_wb_rd == w_rs2) && (w_rs2 != '0)) w_rs2_val = i_wb_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (i_wb_we && (i_wb_rd != '0)) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  // Hold buffer FSM and registered id_* bundle; flush dominates everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_hold_inst  <= '0;
      r_hold_pc    <= '0;
      r_hold_comp  <= 1'b0;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_next_pc <= '0;
      r_id_inst    <= '0;
      r_id_rs1_val <= '0;
      r_id_rs2_val <= '0;
      r_id_imm     <= '0;
      r_id_rd      <= '0;
      r_id_rd_we   <= 1'b0;
      r_id_illegal <= 1'b0;
    end else if (i_flush) begin
      r_state    <= S_EMPTY;
      r_id_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: if (i_inst_valid && !w_accept) begin
          r_state     <= S_FULL;
          r_hold_inst <= i_inst;
          r_hold_pc   <= i_inst_pc;
          r_hold_comp <= i_inst_is_compressed;
        end
        S_FULL:  if (w_accept) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
      if (w_accept) begin
        r_id_valid   <= 1'b1;
        r_id_pc      <= w_src_pc;
        r_id_next_pc <= w_src_pc + (w_src_comp ? XLEN'(2) : XLEN'(4));
        r_id_inst    <= w_src_inst;
        r_id_rs1_val <= w_rs1_val;
        r_id_rs2_val <= w_rs2_val;
        r_id_imm     <= w_imm;
        r_id_rd      <= w_rd;
        r_id_rd_we   <= w_rd_we;
        r_id_illegal <= w_illegal;
      end else if (!i_ex_stall) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign o_id_valid   = r_id_valid;
  assign o_id_pc      = r_id_pc;
  assign o_id_next_pc = r_id_next_pc;
  assign o_id_inst    = r_id_inst;
  assign o_id_rs1_val = r_id_rs1_val;
  assign o_id_rs2_val = r_id_rs2_val;
  assign o_id_imm     = r_id_imm;
  assign o_id_rd      = r_id_rd;
  assign o_id_rd_we   = r_id_rd_we;
  assign o_id_illegal = r_id_illegal;
endmodule

// File: doc/xrv_id.md
XRV_ID -- requirements
Module: xrv_id

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 inst_valid / inst / inst_pc / inst_is_compressed  in  1/32/32/1  decompressed instruction from fetch stage.
REQ-004 stalling  out  1  combinational; fetch stage inhibits its FIFO read while high.
REQ-005 flush  in  1  redirect (same-cycle as fetch jmp); discards all held and issued work.
REQ-006 ex_stall  in  1  execute stage cannot accept a new instruction this cycle.
REQ-007 ex_load_valid / ex_load_rd  in  1/5  load currently in execute and its destination.
REQ-008 wb_we / wb_rd / wb_data  in  1/5/32  register-file write port.
REQ-009 id_valid  out  1  id_* bundle holds a decoded instruction.
REQ-010 id_pc / id_next_pc / id_inst  out  32/32/32  pc, pc+2 (compressed) or pc+4, raw instruction.
REQ-011 id_rs1_val / id_rs2_val / id_imm  out  32/32/32  operands and sign-extended immediate.
REQ-012 id_rd / id_rd_we / id_illegal  out  5/1/1  destination, write enable, illegal opcode.

Function
REQ-013 Register file: 31x32 (x1..x31); x0 reads 0; writes ignored when wb_rd==0.
REQ-014 One-entry hold buffer (states EMPTY/FULL) captures the incoming instruction when not accepted.
REQ-015 Source = hold buffer when FULL, else input when inst_valid.
REQ-016 hazard = ex_load_valid & ex_load_rd!=0 & ((rs1_used & rs1==ex_load_rd) | (rs2_used & rs2==ex_load_rd)).
REQ-017 accept = source present & ~ex_stall & ~hazard & ~flush.
REQ-018 stalling = (hold FULL | inst_valid) & ~accept.
REQ-019 EMPTY->FULL: inst_valid & ~accept & ~flush; FULL->EMPTY: accept or flush.
REQ-020 inst_valid and hold FULL never both high; violation is a design error (bench asserts).
REQ-021 On accept, id_* registered from source next edge, id_valid<=1 (1-cycle latency).
REQ-022 No accept & ~ex_stall: id_valid<=0 (bubble); ex_stall: id_* and id_valid held.
REQ-023 flush: id_valid<=0, hold EMPTY, highest priority over accept, ex_stall, capture.
REQ-024 Immediates: U (LUI/AUIPC), J (JAL), I (JALR/LOAD/OP-IMM/SYSTEM), S (STORE), B (BRANCH), else 0; all sign-extended to 32 bits.
REQ-025 rs1_used: all except LUI/AUIPC/JAL; rs2_used: BRANCH/STORE/OP.
REQ-026 id_rd_we = rd!=0 & opcode not BRANCH/STORE/MISC-MEM; forced 0 when id_illegal.
REQ-027 id_illegal when inst[1:0]!=2'b11 or opcode outside RV32I base set.
REQ-028 id_next_pc = pc + 2 if compressed else pc + 4, modulo 2^32 (wraps at 0xFFFFFFFE/0xFFFFFFFC).
REQ-029 Operands read from source register fields in the accept cycle.

Reset
REQ-030 rst: id_valid=0, hold EMPTY, all id_* outputs 0, x1..x31 = 0, stalling = 0 while inst_valid=0.
REQ-031 rst mid-stall discards held instruction; first post-reset instruction accepted normally.

Configuration
REQ-032 Macro XRV_ID_WB_BYPASS_EN: defined -> read of register being written same cycle returns wb_data.
REQ-033 Undefined -> same-cycle read returns prior register value; write visible next cycle.

Verification
REQ-034 Write x5=0x1234 via wb; issue ADDI x6,x5,1 -> id_valid next cycle, id_rs1_val=0x1234, id_imm=1, id_rd=6.
REQ-035 ex_load_valid=1, ex_load_rd=5, inst ADD x7,x5,x1 -> stalling=1, hold FULL, id_valid=0; drop load -> accepted next edge, no instruction lost or duplicated.
REQ-036 ex_stall=1 for 3 cycles with id_valid=1 -> id_* unchanged 3 cycles; incoming instruction held, released after.
REQ-037 Hold FULL, flush=1 -> next cycle id_valid=0, hold EMPTY, stalling=0.
REQ-038 Same-cycle wb x9=0xDEAD and read x9 -> 0xDEAD with XRV_ID_WB_BYPASS_EN, old value without.
REQ-039 Compressed inst at pc 0xFFFFFFFE -> id_next_pc=0x00000000; inst 0x00000000 -> id_illegal=1, id_rd_we=0.
